// File: rtl/udma_evt_pkg.sv
// Shared types for the uDMA event collector: the 8-bit event-ID carried to the uDMA control block.
package udma_evt_pkg;

  localparam int EVT_ID_W = 8;

  typedef logic [EVT_ID_W-1:0] evt_id_t;

endpackage

// File: rtl/udma_evt_fifo.sv
// Small synchronous FIFO for event IDs; power-of-two depth, head reads as zero when empty.
module udma_evt_fifo
  import udma_evt_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = evt_id_t
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic          do_push, do_pop;

  always_comb begin
    // A full FIFO refuses a push even when the head is popped in the same cycle.
    do_push  = push_i & (cnt_q != CW'(DEPTH));
    do_pop   = pop_i & (cnt_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = empty_o ? T'('0) : mem_q[rd_ptr_q];

endmodule

// File: rtl/udma_evt_collector.sv
// Latches single-cycle event pulses per source, arbitrates them round-robin and
// serialises the winners as event IDs through a small FIFO.
module udma_evt_collector
  import udma_evt_pkg::*;
#(
  parameter int N_EVT_SRC   = 16,
  parameter int EVT_ID_BASE = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [N_EVT_SRC-1:0] evt_i,
  input  logic [N_EVT_SRC-1:0] evt_en_i,
  output logic                 event_valid_o,
  output logic [7:0]           event_data_o,
  input  logic                 event_ready_i,
  output logic [N_EVT_SRC-1:0] evt_lost_o,
  input  logic                 evt_lost_clr_i,
  output logic                 busy_o
);

  localparam int PTR_W = (N_EVT_SRC > 1) ? $clog2(N_EVT_SRC) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [N_EVT_SRC-1:0] pend_q, pend_d;
  logic [N_EVT_SRC-1:0] lost_q, lost_d;
  logic [PTR_W-1:0]     rr_q, rr_d;

  logic                 gnt_found;
  logic                 gnt_vld;
  logic [PTR_W-1:0]     gnt_idx;
  logic [N_EVT_SRC-1:0] gnt_oh;
  logic [N_EVT_SRC-1:0] evt_in;
  evt_id_t              push_id;
  evt_id_t              head_id;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0]     fifo_cnt;
  int                   idx;

  // Round-robin search over the registered pending bits, starting at rr_q.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N_EVT_SRC; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_EVT_SRC) idx = idx - N_EVT_SRC;
      if (!gnt_found && pend_q[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    gnt_vld = gnt_found & ~fifo_full;
    gnt_oh  = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    push_id = evt_id_t'(EVT_ID_BASE + int'(gnt_idx));

    evt_in = evt_i & evt_en_i;
    // A pulse landing on the cycle its source is granted re-arms pending instead of being lost.
    pend_d = (pend_q & ~gnt_oh) | evt_in;
    lost_d = (evt_lost_clr_i ? '0 : lost_q) | (evt_in & pend_q & ~gnt_oh);

    rr_d = rr_q;
    if (gnt_vld) rr_d = (gnt_idx == PTR_W'(N_EVT_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pend_q <= '0;
      lost_q <= '0;
      rr_q   <= '0;
    end else begin
      pend_q <= pend_d;
      lost_q <= lost_d;
      rr_q   <= rr_d;
    end
  end

  udma_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (evt_id_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (gnt_vld),
    .data_i  (push_id),
    .pop_i   (fifo_pop),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign fifo_pop      = event_valid_o & event_ready_i;
  assign event_valid_o = ~fifo_empty;
  assign event_data_o  = head_id;
  assign evt_lost_o    = lost_q;
  assign busy_o        = (|pend_q) | (fifo_cnt != '0);

endmodule

// File: tb/tb_udma_evt_collector.sv
// Directed bench for udma_evt_collector: latency, burst ordering, RR wrap, loss flags,
// enables, ID base offset and mid-burst reset.
module tb_udma_evt_collector;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] evt, en, lost;
  logic        ready, valid, clr, busy;
  logic [7:0]  data;

  logic [3:0]  evt_b, en_b, lost_b;
  logic        ready_b, valid_b, clr_b, busy_b;
  logic [7:0]  data_b;

  int n_chk = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  udma_evt_collector #(.N_EVT_SRC(16), .EVT_ID_BASE(0), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rstn_i(rstn), .evt_i(evt), .evt_en_i(en),
    .event_valid_o(valid), .event_data_o(data), .event_ready_i(ready),
    .evt_lost_o(lost), .evt_lost_clr_i(clr), .busy_o(busy)
  );

  udma_evt_collector #(.N_EVT_SRC(4), .EVT_ID_BASE(32), .FIFO_DEPTH(2)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .evt_i(evt_b), .evt_en_i(en_b),
    .event_valid_o(valid_b), .event_data_o(data_b), .event_ready_i(ready_b),
    .evt_lost_o(lost_b), .evt_lost_clr_i(clr_b), .busy_o(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    evt   = '0;
    clr   = 1'b0;
    evt_b = '0;
    clr_b = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // Pops with ready=1, matching each valid head against exp_q in order.
  task automatic drain(input string tag, input int budget);
    int cyc = 0;
    ready = 1'b1;
    while (exp_q.size() != 0 && cyc < budget) begin
      if (valid) chk(tag, data, exp_q.pop_front());
      tick();
      cyc++;
    end
    if (exp_q.size() != 0) begin
      chk({tag, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) tick();
    chk({tag, "_idle"}, {valid, busy}, 2'b00);
  endtask

  initial begin
    logic seen;
    rstn = 1'b0; evt = '0; en = '1; ready = 1'b0; clr = 1'b0;
    evt_b = '0; en_b = '1; ready_b = 1'b0; clr_b = 1'b0;
    tick(); tick();
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_lost", lost, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;

    // 1: single event latency
    ready = 1'b1;
    evt = 16'h0008; tick(); evt = '0;
    chk("t1_lat1_valid", valid, 0);
    chk("t1_lat1_busy", busy, 1);
    tick();
    chk("t1_valid", valid, 1);
    chk("t1_data", data, 8'h03);
    tick();
    chk("t1_done_valid", valid, 0);
    chk("t1_done_busy", busy, 0);

    // 2: all sources at once, back-pressured then drained in order
    do_reset();
    ready = 1'b0;
    evt = '1; tick(); evt = '0;
    repeat (5) tick();
    chk("t2_full_valid", valid, 1);
    chk("t2_full_head", data, 8'h00);
    chk("t2_full_busy", busy, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back(i);
    drain("t2_order", 200);
    chk("t2_lost", lost, 0);

    // 3: pointer moved to 5 by granting source 4, then {2,5,9}
    do_reset();
    evt = 16'h0010; tick(); evt = '0;
    exp_q.push_back(4);
    drain("t3_setup", 50);
    evt = 16'h0224; tick(); evt = '0;
    exp_q.push_back(5); exp_q.push_back(9); exp_q.push_back(2);
    drain("t3_wrap", 50);

    // 4: loss while FIFO full, clear behaviour
    do_reset();
    ready = 1'b0;
    evt = 16'h000F; tick(); evt = '0;
    repeat (5) tick();
    evt = 16'h0080; tick(); evt = '0;
    tick();
    chk("t4_no_loss_yet", lost, 0);
    evt = 16'h0080; tick(); evt = '0;
    chk("t4_lost7", lost, 16'h0080);
    evt = 16'h0080; clr = 1'b1; tick(); evt = '0; clr = 1'b0;
    chk("t4_clr_vs_loss", lost, 16'h0080);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t4_cleared", lost, 0);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(7);
    drain("t4_order", 100);

    // 5: disabled source, then ID base offset on the second instance
    do_reset();
    en = 16'hFFFD;
    evt = 16'h0002; tick(); evt = '0;
    repeat (4) tick();
    chk("t5_dis_valid", valid, 0);
    chk("t5_dis_busy", busy, 0);
    chk("t5_dis_lost", lost, 0);
    en = '1;
    ready_b = 1'b0;
    evt_b = 4'b0010; tick(); evt_b = '0;
    chk("t5_b_lat", valid_b, 0);
    tick();
    chk("t5_b_valid", valid_b, 1);
    chk("t5_b_data", data_b, 8'h21);
    ready_b = 1'b1; tick();
    chk("t5_b_done", {valid_b, busy_b}, 2'b00);

    // 6: reset with 3 queued and 2 pending
    do_reset();
    ready = 1'b0;
    evt = 16'h001F; tick(); evt = '0;
    tick(); tick(); tick();
    chk("t6_pre_head", data, 8'h00);
    chk("t6_pre_busy", busy, 1);
    rstn = 1'b0; evt = 16'h0100; tick();
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_data", data, 0);
    evt = '0; rstn = 1'b1; ready = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen = seen | valid | busy;
    end
    chk("t6_no_stale", seen, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
